input_port_feeder: RTL
======================

// Module: input_port_feeder
// PURPOSE
//   Host-side input buffer that feeds the Processor's 8-bit input port.
//   Producer bytes are queued in a small FIFO. Each byte is presented to the Processor
//   (in / inDataReady / inACK) over a four-phase req/ack handshake.
//   Decouples bench/host write timing from the Processor's instruction-paced reads.
// PARAMETERS
//   WIDTH   8   data width; matches Processor 'in'
//   DEPTH   8   FIFO entries; power of two, >= 2
//   ADDR_W  3   log2(DEPTH); pointer width
// PORTS
//   clk         in   1         rising-edge clock
//   reset       in   1         synchronous, active-high
//   wr_data     in   WIDTH     producer byte
//   wr_en       in   1         write strobe; accepted when !full
//   full        out  1         count == DEPTH
//   empty       out  1         count == 0
//   count       out  ADDR_W+1  bytes queued, including the byte on offer
//   overflow    out  1         sticky: a write was attempted while full
//   out_data    out  WIDTH     to Processor 'in'; stable while data_ready=1
//   data_ready  out  1         to Processor 'inDataReady'
//   ack         in   1         from Processor 'inACK'
// BEHAVIOUR
//   Reset:
//   - Pointers, count, out_data and data_ready go to 0; overflow is cleared; state is IDLE.
//   - Reset mid-handshake discards all queued data and drops data_ready on the same edge.
//   FIFO:
//   - Write occurs when wr_en && !full at an edge: mem[wr_ptr] <= wr_data, wr_ptr++ (wraps mod DEPTH).
//   - Pop occurs only on the OFFER->RELEASE edge: rd_ptr++ (wraps mod DEPTH).
//   - Write and pop on the same edge leave count unchanged.
//   - full/empty are derived from the registered count (pre-edge value).
//     A write while full is rejected even if a pop happens on the same edge.
//   - Rejected write sets overflow=1 (sticky until reset); FIFO contents are unchanged.
//   FSM (state register; registered outputs):
//   - IDLE:
//     - If !empty && !ack: out_data <= mem[rd_ptr]; data_ready <= 1; go to OFFER.
//     - If ack=1 (stale or illegal): remain in IDLE with data_ready=0.
//   - OFFER:
//     - Hold data_ready=1 and out_data constant.
//     - On ack=1: data_ready <= 0; pop; go to RELEASE.
//     - Waits indefinitely; no timeout.
//   - RELEASE:
//     - data_ready=0; wait for ack=0, then go to IDLE.
//     - The next byte cannot be offered before the IDLE evaluation that follows.
//   Latency and throughput:
//   - Byte written at edge k into an empty FIFO with ack=0: data_ready=1 after edge k+1.
//   - Minimum handshake period is 3 cycles per byte (IDLE, OFFER, RELEASE), plus Processor ack delay.
//   Ordering:
//   - Strict FIFO order; no byte is lost or duplicated across pointer wrap-around.
//   - count includes the byte on offer until its ack edge.
// TESTING
//   1. Reset, then write 0x5A at edge k, ack tied 0
//      -> data_ready=1 and out_data=0x5A after edge k+1; count=1.
//   2. Write 0x11,0x22,0x33; a responder acks 2 cycles after data_ready and releases 1 cycle after its drop
//      -> Processor sees 0x11,0x22,0x33 in order; empty=1 at end.
//   3. Write 9 bytes with no ack
//      -> full=1 and count=8 after the 8th; 9th rejected; overflow=1; first offered byte is byte 1.
//   4. Full FIFO: wr_en coincides with the ack pop edge
//      -> write rejected, count=7, overflow=1.
//      Next cycle, write 0xEE -> accepted, count=8.
//   5. Feed 20 bytes 0x00..0x13 through DEPTH=8 with interleaved writes and acks
//      -> all 20 received in order across pointer wrap; simultaneous write+pop keeps count steady.
//   6. Assert reset while in OFFER with ack=1 held
//      -> data_ready=0 and count=0 next cycle; no new offer until ack drops after new writes.

Source files
------------

// File: rtl/input_port_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : input_port_feeder_if
// Purpose  : Producer write bus plus Processor input-port req/ack handshake.
// Revision : 1.0  initial release
// ============================================================================
interface input_port_feeder_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic [WIDTH-1:0]  wr_data;
    logic              wr_en;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [WIDTH-1:0]  out_data;
    logic              data_ready;
    logic              ack;

    // Host/bench side: writes bytes and plays the Processor's ack.
    modport master (
        output wr_data, wr_en, ack,
        input  full, empty, count, overflow, out_data, data_ready
    );

    modport slave (
        input  wr_data, wr_en, ack,
        output full, empty, count, overflow, out_data, data_ready
    );
endinterface
`default_nettype wire

// File: rtl/input_port_feeder.sv
`default_nettype none
// ============================================================================
// Module   : input_port_feeder
// Purpose  : Byte FIFO feeding the Processor input port over four-phase req/ack.
// Revision : 1.0  initial release
// ============================================================================
module input_port_feeder #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input_port_feeder_if.slave bus
);

    localparam logic [ADDR_W:0] c_FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OFFER   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wrPtr;
    logic [ADDR_W-1:0]  r_rdPtr;
    logic [ADDR_W:0]    r_count;
    logic               r_overflow;
    logic               r_dataReady;
    logic [WIDTH-1:0]   r_outData;

    logic               w_full;
    logic               w_empty;
    logic               w_wrAccept;
    logic               w_pop;

    // full/empty come from the pre-edge count, so a pop cannot make room
    // for a write on the same edge.
    assign w_full     = (r_count == c_FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_wrAccept = bus.wr_en && !w_full;
    assign w_pop      = (r_state == S_OFFER) && bus.ack;

    always_ff @(posedge clk) begin
        if (!reset && w_wrAccept) begin
            r_mem[r_wrPtr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_dataReady <= 1'b0;
            r_outData   <= '0;
            r_state     <= S_IDLE;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end

            case ({w_wrAccept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    // A high ack here is stale; wait for it to drop before offering.
                    if (!w_empty && !bus.ack) begin
                        r_outData   <= r_mem[r_rdPtr];
                        r_dataReady <= 1'b1;
                        r_state     <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (bus.ack) begin
                        r_dataReady <= 1'b0;
                        r_state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!bus.ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_dataReady <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.count      = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.out_data   = r_outData;
    assign bus.data_ready = r_dataReady;

endmodule
`default_nettype wire
